// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - stage-M load/store unit: legality check, bus handshake, load alignment
// One transaction at a time; every output is registered so reset clears them asynchronously.
module mem_access_unit #(
  parameter int          DATA_W     = 32,
  parameter logic [31:0] DM_START   = 32'h0000_0000,
  parameter logic [31:0] DM_END     = 32'h0000_3000,
  parameter logic [31:0] IO_START   = 32'h0000_7F00,
  parameter logic [31:0] IO_END     = 32'h0000_7F20,
  parameter logic [7:0]  IO_RO_MASK = 8'b0100_0100,
  parameter int          TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [31:0]         req_pc,
  input  logic                flush,
  output logic                bus_req,
  output logic                bus_we,
  output logic [31:0]         bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [4:0]          rsp_exc,
  output logic [31:0]         rsp_badaddr,
  output logic [31:0]         rsp_pc
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP, DRAIN} state_t;

  state_t          state;
  logic [WW-1:0]   wdog;
  logic [1:0]      lat_size;
  logic            lat_uns;
  logic [OW-1:0]   lat_off;

  logic [OW-1:0]   off;
  logic [7:0]      be_base;
  logic            misalign, bad_size, in_dm, in_io, io_bad, io_ro, exc_any;
  logic [31:0]     dm_rel, io_rel;
  logic [DATA_W-1:0] sh, mask, ext;
  logic            msb, done;

  // Range checks as offset-below-size so a zero base never folds into a constant compare.
  always_comb begin
    off      = req_addr[OW-1:0];
    misalign = 1'b0;
    be_base  = 8'h01;
    case (req_size)
      2'd0:    begin misalign = 1'b0;            be_base = 8'h01; end
      2'd1:    begin misalign = req_addr[0];     be_base = 8'h03; end
      2'd2:    begin misalign = |req_addr[1:0];  be_base = 8'h0F; end
      default: begin misalign = |req_addr[2:0];  be_base = 8'hFF; end
    endcase
    bad_size = (req_size == 2'd3) && (DATA_W == 32);
    dm_rel   = req_addr - DM_START;
    io_rel   = req_addr - IO_START;
    in_dm    = dm_rel < (DM_END - DM_START);
    in_io    = io_rel < (IO_END - IO_START);
    io_bad   = in_io && ((req_size != 2'd2) || (req_addr[1:0] != 2'b00));
    io_ro    = in_io && req_we && IO_RO_MASK[io_rel[4:2]];
    exc_any  = misalign || bad_size || !(in_dm || in_io) || io_bad || io_ro;
  end

  always_comb begin
    sh   = bus_rdata >> {lat_off, 3'b000};
    msb  = sh[DATA_W-1];
    mask = {DATA_W{1'b1}};
    case (lat_size)
      2'd0:    begin msb = sh[7];  mask = DATA_W'(64'h0000_0000_0000_00FF); end
      2'd1:    begin msb = sh[15]; mask = DATA_W'(64'h0000_0000_0000_FFFF); end
      2'd2:    begin msb = sh[31]; mask = DATA_W'(64'h0000_0000_FFFF_FFFF); end
      default: begin msb = sh[DATA_W-1]; mask = {DATA_W{1'b1}}; end
    endcase
    ext  = (sh & mask) | ({DATA_W{msb & ~lat_uns}} & ~mask);
    done = bus_ack || bus_err || (wdog == WW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wdog        <= '0;
      lat_size    <= '0;
      lat_uns     <= 1'b0;
      lat_off     <= '0;
      req_ready   <= 1'b1;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_exc     <= '0;
      rsp_badaddr <= '0;
      rsp_pc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            req_ready   <= 1'b0;
            rsp_badaddr <= req_addr;
            rsp_pc      <= req_pc;
            rsp_rdata   <= '0;
            lat_size    <= req_size;
            lat_uns     <= req_unsigned;
            lat_off     <= off;
            wdog        <= '0;
            if (exc_any) begin
              rsp_exc   <= req_we ? 5'd5 : 5'd4;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              rsp_exc   <= 5'd0;
              bus_req   <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= {req_addr[31:OW], {OW{1'b0}}};
              bus_be    <= req_we ? NB'(be_base << off) : {NB{1'b1}};
              bus_wdata <= req_wdata << {off, 3'b000};
              state     <= BUS;
            end
          end
        end
        BUS: begin
          if (done) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (flush) begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              rsp_valid <= 1'b1;
              state     <= RESP;
              if (bus_err || !bus_ack) begin
                rsp_exc   <= 5'd7;
                rsp_rdata <= '0;
              end else if (!bus_we) begin
                rsp_rdata <= ext;
              end
            end
          end else begin
            wdog <= wdog + 1'b1;
            if (flush) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The slave must still see its handshake finish; only the response is discarded.
          if (done) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready || flush) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed checks of mem_access_unit at DATA_W=32 and DATA_W=64
// Both instances share stimulus; sel64 picks which one the checks observe.
module tb_mem_access_unit;
  logic        clk, reset;
  logic        req_valid, req_we, req_unsigned, flush, bus_ack, bus_err, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_pc;
  logic [63:0] req_wdata, bus_rdata;
  logic        sel64;

  logic        a_req_ready, a_bus_req, a_bus_we, a_rsp_valid;
  logic [31:0] a_bus_addr, a_bus_wdata, a_rsp_rdata, a_rsp_badaddr, a_rsp_pc;
  logic [3:0]  a_bus_be;
  logic [4:0]  a_rsp_exc;
  logic        b_req_ready, b_bus_req, b_bus_we, b_rsp_valid;
  logic [31:0] b_bus_addr, b_rsp_badaddr, b_rsp_pc;
  logic [63:0] b_bus_wdata, b_rsp_rdata;
  logic [7:0]  b_bus_be;
  logic [4:0]  b_rsp_exc;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.DATA_W(32)) u32 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .req_pc(req_pc), .flush(flush), .bus_req(a_bus_req),
    .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_be(a_bus_be), .bus_wdata(a_bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata[31:0]), .rsp_valid(a_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_exc(a_rsp_exc),
    .rsp_badaddr(a_rsp_badaddr), .rsp_pc(a_rsp_pc)
  );

  mem_access_unit #(.DATA_W(64)) u64 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc), .flush(flush), .bus_req(b_bus_req),
    .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_be(b_bus_be), .bus_wdata(b_bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata), .rsp_valid(b_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_exc(b_rsp_exc),
    .rsp_badaddr(b_rsp_badaddr), .rsp_pc(b_rsp_pc)
  );

  logic        m_req_ready, m_bus_req, m_bus_we, m_rsp_valid;
  logic [31:0] m_bus_addr, m_rsp_badaddr, m_rsp_pc;
  logic [7:0]  m_bus_be;
  logic [63:0] m_bus_wdata, m_rsp_rdata;
  logic [4:0]  m_rsp_exc;
  logic        m_any;

  assign m_req_ready   = sel64 ? b_req_ready   : a_req_ready;
  assign m_bus_req     = sel64 ? b_bus_req     : a_bus_req;
  assign m_bus_we      = sel64 ? b_bus_we      : a_bus_we;
  assign m_rsp_valid   = sel64 ? b_rsp_valid   : a_rsp_valid;
  assign m_bus_addr    = sel64 ? b_bus_addr    : a_bus_addr;
  assign m_rsp_badaddr = sel64 ? b_rsp_badaddr : a_rsp_badaddr;
  assign m_rsp_pc      = sel64 ? b_rsp_pc      : a_rsp_pc;
  assign m_bus_be      = sel64 ? b_bus_be      : {4'h0, a_bus_be};
  assign m_bus_wdata   = sel64 ? b_bus_wdata   : {32'h0, a_bus_wdata};
  assign m_rsp_rdata   = sel64 ? b_rsp_rdata   : {32'h0, a_rsp_rdata};
  assign m_rsp_exc     = sel64 ? b_rsp_exc     : a_rsp_exc;
  assign m_any = m_bus_req | m_bus_we | (|m_bus_addr) | (|m_bus_be) | (|m_bus_wdata) |
                 m_rsp_valid | (|m_rsp_rdata) | (|m_rsp_exc) | (|m_rsp_badaddr) | (|m_rsp_pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [63:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr;
    req_wdata = wdata; req_pc = req_pc + 32'd4; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    mid();
    check({tag, ".rsp_clr"}, m_rsp_valid, 1'b0);
    check({tag, ".ready"}, m_req_ready, 1'b1);
    check({tag, ".bus_idle"}, m_bus_req, 1'b0);
  endtask

  task automatic xfer(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                      input logic [31:0] exp_addr, input logic [7:0] exp_be,
                      input logic [63:0] exp_wdata, input logic [63:0] exp_rdata);
    issue(we, size, uns, addr, wdata);
    bus_ack = 1'b1; bus_rdata = rdata;
    mid();
    check({tag, ".bus_req"}, m_bus_req, 1'b1);
    check({tag, ".busy"}, m_req_ready, 1'b0);
    check({tag, ".bus_addr"}, m_bus_addr, exp_addr);
    check({tag, ".bus_be"}, m_bus_be, exp_be);
    if (we) check({tag, ".bus_wdata"}, m_bus_wdata, exp_wdata);
    step();
    bus_ack = 1'b0;
    mid();
    check({tag, ".rsp_valid"}, m_rsp_valid, 1'b1);
    check({tag, ".rsp_rdata"}, m_rsp_rdata, exp_rdata);
    check({tag, ".rsp_exc"}, m_rsp_exc, 5'd0);
    check({tag, ".badaddr"}, m_rsp_badaddr, addr);
    check({tag, ".pc"}, m_rsp_pc, req_pc);
    finish_rsp(tag);
  endtask

  task automatic exc(input string tag, input logic we, input logic [1:0] size,
                     input logic [31:0] addr, input logic [4:0] exp_exc);
    issue(we, size, 1'b0, addr, 64'h0);
    mid();
    check({tag, ".no_bus"}, m_bus_req, 1'b0);
    check({tag, ".rsp_valid"}, m_rsp_valid, 1'b1);
    check({tag, ".rsp_exc"}, m_rsp_exc, exp_exc);
    check({tag, ".rsp_rdata"}, m_rsp_rdata, 64'h0);
    check({tag, ".badaddr"}, m_rsp_badaddr, addr);
    finish_rsp(tag);
  endtask

  initial begin
    logic seen;
    reset = 1'b0; sel64 = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_unsigned = 1'b0; req_size = 2'd0;
    req_addr = '0; req_pc = 32'h0000_1000; req_wdata = '0;
    flush = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0; rsp_ready = 1'b0;
    step(); step();
    mid();
    check("rst.ready", m_req_ready, 1'b1);
    check("rst.outs", m_any, 1'b0);
    reset = 1'b1;
    step();

    xfer("lw", 1'b0, 2'd2, 1'b0, 32'h10, 64'h0, 64'hDEAD_BEEF, 32'h10, 8'h0F, 64'h0, 64'hDEAD_BEEF);
    xfer("lh", 1'b0, 2'd1, 1'b0, 32'h22, 64'h0, 64'h8001_7FFF, 32'h20, 8'h0F, 64'h0, 64'hFFFF_8001);
    xfer("lhu", 1'b0, 2'd1, 1'b1, 32'h22, 64'h0, 64'h8001_7FFF, 32'h20, 8'h0F, 64'h0, 64'h0000_8001);
    xfer("lb", 1'b0, 2'd0, 1'b0, 32'h13, 64'h0, 64'h8F00_0000, 32'h10, 8'h0F, 64'h0, 64'hFFFF_FF8F);
    xfer("lbu1", 1'b0, 2'd0, 1'b1, 32'h11, 64'h0, 64'h0000_7F00, 32'h10, 8'h0F, 64'h0, 64'h0000_007F);
    xfer("sh2", 1'b1, 2'd1, 1'b0, 32'h2E, 64'hBEEF, 64'h0, 32'h2C, 8'h0C, 64'hBEEF_0000, 64'h0);
    xfer("sw_io", 1'b1, 2'd2, 1'b0, 32'h7F0C, 64'h55AA, 64'h0, 32'h7F0C, 8'h0F, 64'h55AA, 64'h0);
    xfer("lw_dm_top", 1'b0, 2'd2, 1'b0, 32'h2FFC, 64'h0, 64'h0123_4567, 32'h2FFC, 8'h0F, 64'h0, 64'h0123_4567);

    // Store byte with one wait cycle: bus outputs must hold while waiting.
    issue(1'b1, 2'd0, 1'b0, 32'h13, 64'hAB);
    mid();
    check("sb.bus_addr", m_bus_addr, 32'h10);
    check("sb.bus_be", m_bus_be, 8'h08);
    check("sb.bus_wdata", m_bus_wdata, 64'hAB00_0000);
    check("sb.bus_we", m_bus_we, 1'b1);
    step(); bus_ack = 1'b1;
    mid();
    check("sb.wait_rsp", m_rsp_valid, 1'b0);
    check("sb.hold_wdata", m_bus_wdata, 64'hAB00_0000);
    step(); bus_ack = 1'b0;
    mid();
    check("sb.rsp_valid", m_rsp_valid, 1'b1);
    check("sb.rsp_rdata", m_rsp_rdata, 64'h0);
    finish_rsp("sb");

    exc("sw_ro", 1'b1, 2'd2, 32'h7F08, 5'd5);
    exc("sw_ro6", 1'b1, 2'd2, 32'h7F18, 5'd5);
    exc("lb_io", 1'b0, 2'd0, 32'h7F00, 5'd4);
    exc("lw_hole", 1'b0, 2'd2, 32'h4000, 5'd4);
    exc("lh_mis", 1'b0, 2'd1, 32'h1, 5'd4);
    exc("lw_dm_end", 1'b0, 2'd2, 32'h3000, 5'd4);
    exc("lw_io_end", 1'b0, 2'd2, 32'h7F20, 5'd4);
    exc("sw_mis", 1'b1, 2'd2, 32'h22, 5'd5);

    // Bus error together with ack counts as an error.
    issue(1'b0, 2'd2, 1'b0, 32'h40, 64'h0);
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 64'h1111_2222;
    step(); bus_ack = 1'b0; bus_err = 1'b0;
    mid();
    check("err.rsp_valid", m_rsp_valid, 1'b1);
    check("err.rsp_exc", m_rsp_exc, 5'd7);
    check("err.rsp_rdata", m_rsp_rdata, 64'h0);
    finish_rsp("err");

    // Timeout with no ack: response at T+17.
    issue(1'b0, 2'd2, 1'b0, 32'h20, 64'h0);
    seen = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      mid();
      seen = seen | m_rsp_valid | !m_bus_req;
      step();
    end
    mid();
    check("tmo.early", seen, 1'b0);
    check("tmo.rsp_valid", m_rsp_valid, 1'b1);
    check("tmo.rsp_exc", m_rsp_exc, 5'd7);
    check("tmo.bus_rel", m_bus_req, 1'b0);
    finish_rsp("tmo");

    // Flush at T+3 while in BUS, ack at T+5; no response, ready at T+6.
    issue(1'b0, 2'd2, 1'b0, 32'h20, 64'h0);
    seen = 1'b0;
    mid(); seen = seen | m_rsp_valid;
    step();
    mid(); seen = seen | m_rsp_valid;
    step(); flush = 1'b1;
    mid(); seen = seen | m_rsp_valid;
    step(); flush = 1'b0;
    mid(); seen = seen | m_rsp_valid;
    check("fl.drain_req", m_bus_req, 1'b1);
    check("fl.drain_busy", m_req_ready, 1'b0);
    step(); bus_ack = 1'b1; bus_rdata = 64'h5A5A_5A5A;
    mid(); seen = seen | m_rsp_valid;
    step(); bus_ack = 1'b0;
    mid(); seen = seen | m_rsp_valid;
    check("fl.ready", m_req_ready, 1'b1);
    check("fl.bus_rel", m_bus_req, 1'b0);
    step();
    mid(); seen = seen | m_rsp_valid;
    check("fl.no_rsp", seen, 1'b0);

    // Flush in IDLE blocks an accept on the same cycle.
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10; req_valid = 1'b1; flush = 1'b1;
    step(); req_valid = 1'b0; flush = 1'b0;
    mid();
    check("fl_idle.ready", m_req_ready, 1'b1);
    check("fl_idle.no_bus", m_bus_req, 1'b0);
    check("fl_idle.no_rsp", m_rsp_valid, 1'b0);

    // Flush in RESP drops the response.
    issue(1'b0, 2'd2, 1'b0, 32'h4000, 64'h0);
    mid();
    check("fl_rsp.valid", m_rsp_valid, 1'b1);
    flush = 1'b1;
    step(); flush = 1'b0;
    mid();
    check("fl_rsp.dropped", m_rsp_valid, 1'b0);
    check("fl_rsp.ready", m_req_ready, 1'b1);

    sel64 = 1'b1;
    xfer("sd", 1'b1, 2'd3, 1'b0, 32'h18, 64'h1122_3344_5566_7788, 64'h0,
         32'h18, 8'hFF, 64'h1122_3344_5566_7788, 64'h0);
    xfer("lw64", 1'b0, 2'd2, 1'b0, 32'h1C, 64'h0, 64'h1234_5678_0000_0000,
         32'h18, 8'hFF, 64'h0, 64'h0000_0000_1234_5678);
    xfer("lw64neg", 1'b0, 2'd2, 1'b0, 32'h1C, 64'h0, 64'h8000_0001_0000_0000,
         32'h18, 8'hFF, 64'h0, 64'hFFFF_FFFF_8000_0001);
    xfer("lwu64", 1'b0, 2'd2, 1'b1, 32'h1C, 64'h0, 64'h8000_0001_0000_0000,
         32'h18, 8'hFF, 64'h0, 64'h0000_0000_8000_0001);
    xfer("sb64", 1'b1, 2'd0, 1'b0, 32'h1F, 64'hC3, 64'h0, 32'h18, 8'h80, 64'hC300_0000_0000_0000, 64'h0);

    // SD is illegal at DATA_W=32; the 64-bit unit meanwhile sits in BUS with no ack.
    sel64 = 1'b0;
    exc("sd32", 1'b1, 2'd3, 32'h18, 5'd5);
    sel64 = 1'b1;
    step();
    mid();
    check("rst64.in_bus", m_bus_req, 1'b1);
    check("rst64.be_held", m_bus_be, 8'hFF);
    #2 reset = 1'b0;
    #1;
    check("rst64.ready", m_req_ready, 1'b1);
    check("rst64.outs", m_any, 1'b0);
    sel64 = 1'b0;
    check("rst32.ready", m_req_ready, 1'b1);
    check("rst32.outs", m_any, 1'b0);
    mid();
    reset = 1'b1;
    step();

    sel64 = 1'b1;
    xfer("post_rst", 1'b0, 2'd3, 1'b0, 32'h28, 64'h0, 64'hFEDC_BA98_7654_3210,
         32'h28, 8'hFF, 64'h0, 64'hFEDC_BA98_7654_3210);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
